apb_i2c_master: RTL and testbench

- APB-attached single-master I2C controller, one of the APB peripherals behind the SoC demux; owns IRQ line 6.
- Software programs a prescaler, TX byte and a command word.
- The block generates START/byte write/byte read/ACK/STOP on open-drain SCL/SDA pads.
- It raises a level interrupt on command completion.

---
 rtl/apb_i2c_master.sv | 211 +++++++++++++++++++++
 tb/tb_apb_i2c_master.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_i2c_master.sv
// APB-attached single-master I2C controller: prescaled 4-phase bit engine
// generating START / byte write / byte read / STOP on open-drain pads.
module apb_i2c_master #(
  parameter int unsigned APB_ADDR_WIDTH = 12
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic                      interrupt_o,
  input  logic                      scl_pad_i,
  output logic                      scl_pad_o,
  output logic                      scl_padoen_o,
  input  logic                      sda_pad_i,
  output logic                      sda_pad_o,
  output logic                      sda_padoen_o
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_WRITE, S_READ, S_STOP} state_t;

  state_t      state_q, state_d;
  logic [15:0] pre_q, cnt_q;
  logic [1:0]  phase_q;
  logic [3:0]  bit_q;
  logic [7:0]  rx_q, tx_q, sr_q;
  logic        en_q, ien_q, rxack_q, busy_q, al_q, tip_q, if_q;
  logic        sta_q, sto_q, rd_q, wr_q, ack_q;
  logic        scl_s1, scl_s2, sda_s1, sda_s2, scl_rel_d1, scl_rel_d2;
  logic        scl_oen, sda_oen, seq_done;
  logic [2:0]  addr;
  logic        apb_wr, cmd_wr, ctrl_wr, cmd_go, abort;
  logic        hold, tick, sample, last_bit, op_end, al_hit;
  logic        unused_bits;

  assign addr        = PADDR[4:2];
  assign apb_wr      = PSEL & PENABLE & PWRITE;
  assign cmd_wr      = apb_wr & (addr == 3'd5);
  assign ctrl_wr     = apb_wr & (addr == 3'd1);
  assign cmd_go      = cmd_wr & en_q & ~tip_q & (|PWDATA[7:4]);
  assign abort       = tip_q & ((ctrl_wr & ~PWDATA[7]) | ~en_q);
  assign unused_bits = ^{PADDR[APB_ADDR_WIDTH-1:5], PADDR[1:0], PWDATA[31:16], sta_q};

  // Stretch only counts once the synchroniser reflects our own release,
  // so the 2-cycle input latency never masquerades as a held-low SCL.
  assign hold     = scl_oen & scl_rel_d2 & ~scl_s2;
  assign tick     = (state_q != S_IDLE) & ~hold & (cnt_q == pre_q);
  assign sample   = tick & (phase_q == 2'd2);
  assign last_bit = (bit_q == 4'd8);
  assign op_end   = tick & (phase_q == 2'd3) &
                    ((state_q == S_START) | (state_q == S_STOP) | last_bit);
  assign al_hit   = sample & (state_q == S_WRITE) & ~last_bit & sr_q[7] & ~sda_s2;

  always_comb begin
    state_d  = state_q;
    scl_oen  = 1'b1;
    sda_oen  = 1'b1;
    seq_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_go) begin
          if (PWDATA[7])      state_d = S_START;
          else if (PWDATA[4]) state_d = S_WRITE;
          else if (PWDATA[5]) state_d = S_READ;
          else                state_d = S_STOP;
        end
      end
      S_START: begin
        scl_oen = (phase_q != 2'd3);
        sda_oen = ~phase_q[1];
        if (op_end) begin
          if (wr_q)       state_d = S_WRITE;
          else if (rd_q)  state_d = S_READ;
          else if (sto_q) state_d = S_STOP;
          else begin
            state_d  = S_IDLE;
            seq_done = 1'b1;
          end
        end
      end
      S_WRITE, S_READ: begin
        scl_oen = phase_q[0] ^ phase_q[1];
        sda_oen = (state_q == S_WRITE) ? (last_bit | sr_q[7]) : (~last_bit | ack_q);
        if (op_end) begin
          if (sto_q) state_d = S_STOP;
          else begin
            state_d  = S_IDLE;
            seq_done = 1'b1;
          end
        end
      end
      S_STOP: begin
        scl_oen = (phase_q != 2'd0);
        sda_oen = phase_q[1];
        if (op_end) begin
          state_d  = S_IDLE;
          seq_done = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (al_hit) begin
      state_d  = S_IDLE;
      seq_done = 1'b1;
    end
    if (abort) begin
      state_d  = S_IDLE;
      seq_done = 1'b0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      phase_q <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        cnt_q   <= '0;
        phase_q <= '0;
        bit_q   <= '0;
      end else if (state_q != S_IDLE && !hold) begin
        if (cnt_q == pre_q) begin
          cnt_q   <= '0;
          phase_q <= phase_q + 2'd1;
          if (phase_q == 2'd3) bit_q <= bit_q + 4'd1;
        end else begin
          cnt_q <= cnt_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      pre_q <= '1;
      {en_q, ien_q, rxack_q, busy_q, al_q, tip_q, if_q} <= '0;
      {sta_q, sto_q, rd_q, wr_q, ack_q} <= '0;
      rx_q  <= '0;
      tx_q  <= '0;
      sr_q  <= '0;
      {scl_s1, scl_s2, sda_s1, sda_s2, scl_rel_d1, scl_rel_d2} <= '1;
    end else begin
      scl_s1     <= scl_pad_i;
      scl_s2     <= scl_s1;
      sda_s1     <= sda_pad_i;
      sda_s2     <= sda_s1;
      scl_rel_d1 <= scl_oen;
      scl_rel_d2 <= scl_rel_d1;
      if (apb_wr && addr == 3'd0 && !tip_q) pre_q <= PWDATA[15:0];
      if (ctrl_wr) {en_q, ien_q} <= PWDATA[7:6];
      if (apb_wr && addr == 3'd4) tx_q <= PWDATA[7:0];
      if (cmd_wr && PWDATA[0]) if_q <= 1'b0;
      if (cmd_go) begin
        tip_q <= 1'b1;
        al_q  <= 1'b0;
        {sta_q, sto_q, rd_q, wr_q} <= PWDATA[7:4];
        ack_q <= PWDATA[3];
        sr_q  <= tx_q;
      end
      if (tick && phase_q == 2'd3 && state_q == S_WRITE) sr_q <= {sr_q[6:0], 1'b0};
      if (sample && state_q == S_READ && !last_bit) begin
        sr_q <= {sr_q[6:0], sda_s2};
        if (bit_q == 4'd7) rx_q <= {sr_q[6:0], sda_s2};
      end
      if (sample && state_q == S_WRITE && last_bit) rxack_q <= sda_s2;
      if (op_end && state_q == S_START) busy_q <= 1'b1;
      if (op_end && state_q == S_STOP)  busy_q <= 1'b0;
      if (al_hit) begin
        al_q   <= 1'b1;
        busy_q <= 1'b0;
      end
      if (seq_done) begin
        tip_q <= 1'b0;
        if_q  <= 1'b1;
      end
      if (abort) begin
        tip_q  <= 1'b0;
        busy_q <= 1'b0;
      end
    end
  end

  always_comb begin
    PRDATA = '0;
    case (addr)
      3'd0: PRDATA = {16'h0, pre_q};
      3'd1: PRDATA = {24'h0, en_q, ien_q, 6'h0};
      3'd2: PRDATA = {24'h0, rx_q};
      3'd3: PRDATA = {24'h0, rxack_q, busy_q, al_q, 3'h0, tip_q, if_q};
      3'd4: PRDATA = {24'h0, tx_q};
      default: PRDATA = '0;
    endcase
  end

  assign PREADY       = 1'b1;
  assign PSLVERR      = 1'b0;
  assign interrupt_o  = if_q & ien_q;
  assign scl_pad_o    = 1'b0;
  assign sda_pad_o    = 1'b0;
  assign scl_padoen_o = scl_oen;
  assign sda_padoen_o = sda_oen;

endmodule

// File: tb/tb_apb_i2c_master.sv
// Directed bench for apb_i2c_master: APB driver, open-drain bus with a
// scripted slave (ACK / byte source / arbitration / clock stretch) and a line monitor.
module tb_apb_i2c_master;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE, PSEL, PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR, interrupt_o;
  logic        scl_pad_i, scl_pad_o, scl_padoen_o;
  logic        sda_pad_i, sda_pad_o, sda_padoen_o;

  logic        s_scl_low = 1'b0;
  logic        s_sda_low = 1'b0;
  int          slave_mode = 0;   // 0 idle, 1 ACK 9th bit, 2 send rd_byte, 3 hold SDA low
  logic [7:0]  rd_byte = 8'h00;
  logic        stretch_en = 1'b0;
  int          arm_seq = 0;

  int          falls, rises, starts, stops, cyc;
  logic        rec_sda [1:16];
  int          rise_t  [1:16];

  int          n_vec = 0;
  int          n_err = 0;

  assign scl_pad_i = scl_padoen_o & ~s_scl_low;
  assign sda_pad_i = sda_padoen_o & ~s_sda_low;

  always #5 HCLK = ~HCLK;

  apb_i2c_master #(.APB_ADDR_WIDTH(12)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA),
    .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .interrupt_o(interrupt_o),
    .scl_pad_i(scl_pad_i), .scl_pad_o(scl_pad_o), .scl_padoen_o(scl_padoen_o),
    .sda_pad_i(sda_pad_i), .sda_pad_o(sda_pad_o), .sda_padoen_o(sda_padoen_o)
  );

  // Bus monitor and slave, evaluated on the falling HCLK edge.
  initial begin
    int   seen, st_cnt;
    logic stretched, prev_scl, prev_sda, scl_now, sda_now;
    seen = 0; st_cnt = 0; stretched = 1'b0;
    prev_scl = 1'b1; prev_sda = 1'b1;
    falls = 0; rises = 0; starts = 0; stops = 0; cyc = 0;
    forever begin
      @(negedge HCLK);
      cyc++;
      if (seen != arm_seq) begin
        seen = arm_seq; falls = 0; rises = 0; starts = 0; stops = 0;
        st_cnt = 0; stretched = 1'b0;
      end
      scl_now = scl_padoen_o & ~s_scl_low;
      sda_now = sda_padoen_o & ~s_sda_low;
      if (prev_scl && !scl_now) falls++;
      if (!prev_scl && scl_now) begin
        rises++;
        if (rises <= 16) begin
          rec_sda[rises] = sda_now;
          rise_t[rises]  = cyc;
        end
      end
      if (prev_scl && scl_now && prev_sda && !sda_now) starts++;
      if (prev_scl && scl_now && !prev_sda && sda_now) stops++;
      prev_scl = scl_now;
      prev_sda = sda_now;
      case (slave_mode)
        1:       s_sda_low = (falls == 9);
        2:       s_sda_low = (falls >= 1 && falls <= 8) ? !rd_byte[8-falls] : 1'b0;
        3:       s_sda_low = (falls >= 1);
        default: s_sda_low = 1'b0;
      endcase
      if (stretch_en && falls == 4 && !stretched) begin
        s_scl_low = 1'b1;
        if (scl_padoen_o) begin
          if (st_cnt == 20) begin
            s_scl_low = 1'b0;
            stretched = 1'b1;
          end else begin
            st_cnt++;
          end
        end
      end else begin
        s_scl_low = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
    @(negedge HCLK);
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = a; PWDATA = d;
    @(negedge HCLK);
    PENABLE = 1'b1;
    @(negedge HCLK);
    PSEL = 1'b0; PWRITE = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] d);
    @(negedge HCLK);
    PADDR = a;
    #1 d = PRDATA;
  endtask

  task automatic wait_tip(output int n);
    n = 0;
    PADDR = 12'h00C;
    #1;
    while (PRDATA[1] && n < 3000) begin
      n++;
      @(negedge HCLK);
      #1;
    end
    if (n >= 3000) check("tip_timeout", 32'd1, 32'd0);
  endtask

  function automatic logic [7:0] rec_byte();
    logic [7:0] b;
    b = '0;
    for (int i = 1; i <= 8; i++) b = {b[6:0], rec_sda[i]};
    return b;
  endfunction

  initial begin
    logic [31:0] d;
    int n;
    HRESETn = 1'b0; PADDR = '0; PWDATA = '0; PWRITE = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;

    apb_read(12'h000, d); check("rst_pre", d, 32'h0000FFFF);
    apb_read(12'h004, d); check("rst_ctrl", d, 32'h0);
    apb_read(12'h00C, d); check("rst_status", d, 32'h0);
    check("rst_scl_oen", {31'b0, scl_padoen_o}, 32'd1);
    check("rst_sda_oen", {31'b0, sda_padoen_o}, 32'd1);
    check("rst_irq", {31'b0, interrupt_o}, 32'd0);

    // START + write 0xA4, slave ACKs
    apb_write(12'h000, 32'd1);
    apb_write(12'h004, 32'hC0);
    apb_write(12'h010, 32'hA4);
    slave_mode = 1; arm_seq++;
    apb_write(12'h014, 32'h90);
    wait_tip(n);
    check("wr_cycles", n, 32'd80);
    check("wr_bits", {24'h0, rec_byte()}, 32'hA4);
    check("wr_bit_time", rise_t[9] - rise_t[1], 32'd64);
    check("wr_start", starts, 32'd1);
    apb_read(12'h00C, d); check("wr_status", d, 32'h41);
    check("wr_irq", {31'b0, interrupt_o}, 32'd1);
    apb_write(12'h014, 32'h01);
    apb_read(12'h00C, d); check("iack_status", d, 32'h40);
    check("iack_irq", {31'b0, interrupt_o}, 32'd0);

    // read 0x5A with NACK, then STOP
    slave_mode = 2; rd_byte = 8'h5A; arm_seq++;
    apb_write(12'h014, 32'h68);
    wait_tip(n);
    check("rd_cycles", n, 32'd80);
    apb_read(12'h008, d); check("rd_rx", d, 32'h5A);
    check("rd_line", {24'h0, rec_byte()}, 32'h5A);
    check("rd_nack", {31'b0, rec_sda[9]}, 32'd1);
    check("rd_stop", stops, 32'd1);
    apb_read(12'h00C, d); check("rd_status", d, 32'h01);
    apb_write(12'h014, 32'h01);

    // clock stretch of 20 cycles in phase B of bit 3
    apb_write(12'h010, 32'h3C);
    slave_mode = 1; stretch_en = 1'b1; arm_seq++;
    apb_write(12'h014, 32'h90);
    wait_tip(n);
    check("st_cycles", n, 32'd100);
    check("st_bits", {24'h0, rec_byte()}, 32'h3C);
    apb_read(12'h00C, d); check("st_status", d, 32'h41);
    stretch_en = 1'b0;
    apb_write(12'h014, 32'h01);

    // arbitration loss on bit 0
    apb_write(12'h010, 32'hFF);
    slave_mode = 3; arm_seq++;
    apb_write(12'h014, 32'h90);
    wait_tip(n);
    apb_read(12'h00C, d); check("al_status", d, 32'h21);
    check("al_scl_oen", {31'b0, scl_padoen_o}, 32'd1);
    check("al_sda_oen", {31'b0, sda_padoen_o}, 32'd1);
    check("al_no_stop", stops, 32'd0);
    check("al_irq", {31'b0, interrupt_o}, 32'd1);
    slave_mode = 0;
    repeat (4) @(negedge HCLK);
    apb_write(12'h014, 32'h01);

    // disabled core ignores commands
    arm_seq++;
    apb_write(12'h004, 32'h40);
    apb_write(12'h014, 32'h90);
    repeat (20) @(negedge HCLK);
    check("dis_falls", falls, 32'd0);
    apb_read(12'h00C, d); check("dis_status", d, 32'h20);

    // EN cleared mid-write; PRE write during TIP ignored
    apb_write(12'h004, 32'hC0);
    apb_write(12'h010, 32'h55);
    arm_seq++;
    apb_write(12'h014, 32'h90);
    repeat (30) @(negedge HCLK);
    apb_write(12'h000, 32'd5);
    apb_write(12'h004, 32'h40);
    check("ab_scl_oen", {31'b0, scl_padoen_o}, 32'd1);
    check("ab_sda_oen", {31'b0, sda_padoen_o}, 32'd1);
    check("ab_activity", {31'b0, falls > 0}, 32'd1);
    apb_read(12'h00C, d); check("ab_status", d, 32'h00);
    apb_read(12'h000, d); check("ab_pre", d, 32'd1);
    check("ab_irq", {31'b0, interrupt_o}, 32'd0);
    apb_read(12'h014, d); check("cmd_read", d, 32'h0);
    apb_read(12'h018, d); check("unmapped_read", d, 32'h0);

    // reset mid-transfer
    apb_write(12'h004, 32'hC0);
    apb_write(12'h014, 32'h90);
    repeat (20) @(negedge HCLK);
    HRESETn = 1'b0;
    repeat (2) @(negedge HCLK);
    check("mr_scl_oen", {31'b0, scl_padoen_o}, 32'd1);
    check("mr_sda_oen", {31'b0, sda_padoen_o}, 32'd1);
    HRESETn = 1'b1;
    apb_read(12'h000, d); check("mr_pre", d, 32'h0000FFFF);
    apb_read(12'h004, d); check("mr_ctrl", d, 32'h0);
    apb_read(12'h00C, d); check("mr_status", d, 32'h0);
    check("mr_irq", {31'b0, interrupt_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
